// File: rtl/dram_sched.sv
// dram_sched: round-robin scheduler in front of a single DRAM command port.
// Tracks the open row of every bank and issues PRE/ACT/RD-WR with
// programmable spacing. One access is in flight at a time. Rows stay open
// after an access.
module dram_sched #(
    parameter int ADDR_WIDTH      = 13,
    parameter int DATA_WIDTH      = 1,
    parameter int NUM_REQ         = 8,
    parameter int NUMBER_OF_BANKS = 8,
    parameter int ROW_BITS        = 7,
    parameter int COL_BITS        = 3,
    parameter int T_RCD           = 2,
    parameter int T_RP            = 2,
    parameter int T_CL            = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr,
    input  logic [NUM_REQ-1:0]                   req_rw,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wdata,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output logic [1:0]                           cmd,
    output logic                                 cmd_we,
    output logic [$clog2(NUMBER_OF_BANKS)-1:0]   cmd_bank,
    output logic [ROW_BITS-1:0]                  cmd_row,
    output logic [COL_BITS-1:0]                  cmd_col,
    output logic [DATA_WIDTH-1:0]                dram_data_out,
    input  logic [DATA_WIDTH-1:0]                dram_data_in,
    output logic                                 busy
);
    localparam int BANK_BITS = $clog2(NUMBER_OF_BANKS);
    localparam int RW        = $clog2(NUM_REQ);
    localparam int TMAX0     = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int TMAX      = (TMAX0 > T_CL) ? TMAX0 : T_CL;
    localparam int CW        = $clog2(TMAX + 1);

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_ACT = 2'b01;
    localparam logic [1:0] CMD_RW  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [2:0] {
        IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, ACCESS, RD_WAIT, RESP
    } state_t;

    state_t state, next_state;

    logic [RW-1:0]         rr_ptr;
    logic [RW-1:0]         owner;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_rw;
    logic [DATA_WIDTH-1:0] lat_wdata;

    // open-row table
    logic [NUMBER_OF_BANKS-1:0]               row_vld;
    logic [NUMBER_OF_BANKS-1:0][ROW_BITS-1:0] row_tab;

    logic                  win_found;
    logic [RW-1:0]         win_idx;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_rw;
    logic [DATA_WIDTH-1:0] win_wdata;

    // In IDLE the decision uses the incoming winner so the first command can
    // be registered on the grant edge; afterwards the latched copy is used.
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_rw;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [BANK_BITS-1:0]  cur_bank;
    logic [ROW_BITS-1:0]   cur_row;
    logic [COL_BITS-1:0]   cur_col;
    logic                  cur_hit;

    logic [1:0]            cmd_n;
    logic                  cmd_we_n;
    logic [BANK_BITS-1:0]  cmd_bank_n;
    logic [ROW_BITS-1:0]   cmd_row_n;
    logic [COL_BITS-1:0]   cmd_col_n;
    logic [DATA_WIDTH-1:0] dout_n;
    logic [NUM_REQ-1:0]    rsp_valid_n;
    logic [DATA_WIDTH-1:0] rsp_data_n;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping
    always_comb begin
        int j;
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = RW'(j);
            end
        end
    end

    // Winner payload, current-request mux and open-row lookup
    always_comb begin
        win_addr  = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        win_rw    = req_rw[win_idx];
        win_wdata = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        cur_addr  = (state == IDLE) ? win_addr  : lat_addr;
        cur_rw    = (state == IDLE) ? win_rw    : lat_rw;
        cur_wdata = (state == IDLE) ? win_wdata : lat_wdata;
        cur_col   = cur_addr[COL_BITS-1:0];
        cur_row   = cur_addr[COL_BITS +: ROW_BITS];
        cur_bank  = cur_addr[COL_BITS+ROW_BITS +: BANK_BITS];
        cur_hit   = row_vld[cur_bank] && (row_tab[cur_bank] == cur_row);
    end

    // Grant strobe: combinational, only in IDLE and never during reset
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && win_found)
            req_ready[win_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (win_found) begin
                if (cur_hit)                next_state = ACCESS;
                else if (row_vld[cur_bank]) next_state = PRE;
                else                        next_state = ACT;
            end
            PRE:      next_state = (T_RP == 1) ? ACT : PRE_WAIT;
            PRE_WAIT: if (int'(cnt) >= T_RP - 1) next_state = ACT;
            ACT:      next_state = (T_RCD == 1) ? ACCESS : ACT_WAIT;
            ACT_WAIT: if (int'(cnt) >= T_RCD - 1) next_state = ACCESS;
            ACCESS:   next_state = lat_rw ? RESP : RD_WAIT;
            RD_WAIT:  if (int'(cnt) >= T_CL) next_state = RESP;
            RESP:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Wait counter: 1 on the first cycle of a wait state, counting up while it holds
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= CW'(1);
        else if ((state == PRE_WAIT || state == ACT_WAIT || state == RD_WAIT) &&
                 next_state == state)
            cnt <= cnt + CW'(1);
        else
            cnt <= CW'(1);
    end

    // Request latch, round-robin pointer and open-row table maintenance
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            owner     <= '0;
            lat_addr  <= '0;
            lat_rw    <= 1'b0;
            lat_wdata <= '0;
            row_vld   <= '0;
            row_tab   <= '0;
        end else begin
            if (state == IDLE && win_found) begin
                lat_addr  <= win_addr;
                lat_rw    <= win_rw;
                lat_wdata <= win_wdata;
                owner     <= win_idx;
                rr_ptr    <= RW'((int'(win_idx) + 1) % NUM_REQ);
            end
            if (next_state == PRE && state != PRE)
                row_vld[cur_bank] <= 1'b0;
            if (next_state == ACT && state != ACT) begin
                row_vld[cur_bank] <= 1'b1;
                row_tab[cur_bank] <= cur_row;
            end
        end
    end

    // Output decode from the next state so commands and responses are registered
    always_comb begin
        cmd_n       = CMD_NOP;
        cmd_we_n    = 1'b0;
        cmd_bank_n  = '0;
        cmd_row_n   = '0;
        cmd_col_n   = '0;
        dout_n      = '0;
        rsp_valid_n = '0;
        rsp_data_n  = '0;
        case (next_state)
            PRE: begin
                cmd_n      = CMD_PRE;
                cmd_bank_n = cur_bank;
            end
            ACT: begin
                cmd_n      = CMD_ACT;
                cmd_bank_n = cur_bank;
                cmd_row_n  = cur_row;
            end
            ACCESS: begin
                cmd_n      = CMD_RW;
                cmd_we_n   = cur_rw;
                cmd_bank_n = cur_bank;
                cmd_row_n  = cur_row;
                cmd_col_n  = cur_col;
                dout_n     = cur_rw ? cur_wdata : '0;
            end
            RESP: begin
                rsp_valid_n[owner] = 1'b1;
                rsp_data_n         = lat_rw ? '0 : dram_data_in;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd           <= CMD_NOP;
            cmd_we        <= 1'b0;
            cmd_bank      <= '0;
            cmd_row       <= '0;
            cmd_col       <= '0;
            dram_data_out <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
        end else begin
            cmd           <= cmd_n;
            cmd_we        <= cmd_we_n;
            cmd_bank      <= cmd_bank_n;
            cmd_row       <= cmd_row_n;
            cmd_col       <= cmd_col_n;
            dram_data_out <= dout_n;
            rsp_valid     <= rsp_valid_n;
            rsp_data      <= rsp_data_n;
        end
    end
endmodule

// File: tb/tb_dram_sched.sv
// Scoreboard bench for dram_sched: stimulus pushes expected commands and
// responses (with their cycle) into queues, monitors pop and compare.
module tb_dram_sched;
    localparam int T_RCD = 2;
    localparam int T_RP  = 2;
    localparam int T_CL  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req_valid;
    logic [103:0] req_addr;
    logic [7:0]  req_rw;
    logic [7:0]  req_wdata;
    logic [7:0]  req_ready;
    logic [7:0]  rsp_valid;
    logic        rsp_data;
    logic [1:0]  cmd;
    logic        cmd_we;
    logic [2:0]  cmd_bank;
    logic [6:0]  cmd_row;
    logic [2:0]  cmd_col;
    logic        dram_data_out;
    logic        dram_data_in;
    logic        busy;

    dram_sched #(.T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_rw(req_rw), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cmd(cmd), .cmd_we(cmd_we),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .dram_data_out(dram_data_out), .dram_data_in(dram_data_in), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] cmd;
        logic       we;
        logic [2:0] bank;
        logic [6:0] row;
        logic [2:0] col;
        logic       dout;
    } cmd_t;

    typedef struct {
        int         cyc;
        logic [7:0] vld;
        logic       data;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    int compared   = 0;
    int mismatched = 0;

    int   samp_cyc = -1;
    logic samp_val = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // DRAM read data model: the wanted value only in the exact sampling cycle
    always @(negedge clk) dram_data_in = (cyc == samp_cyc) ? samp_val : ~samp_val;

    // Command monitor
    always @(negedge clk) begin
        if (!rst) begin
            while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
                chk("cmd_missing_at_cycle", 64'(cyc), 64'(cmd_q[0].cyc));
                void'(cmd_q.pop_front());
            end
            if (cmd != 2'b00) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", 64'(cmd), 64'(0));
                end else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    chk("cmd_cycle", 64'(cyc), 64'(e.cyc));
                    chk("cmd_code", 64'(cmd), 64'(e.cmd));
                    chk("cmd_bank", 64'(cmd_bank), 64'(e.bank));
                    if (e.cmd == 2'b01) chk("cmd_row", 64'(cmd_row), 64'(e.row));
                    if (e.cmd == 2'b10) begin
                        chk("cmd_col", 64'(cmd_col), 64'(e.col));
                        chk("cmd_we", 64'(cmd_we), 64'(e.we));
                        chk("dram_data_out", 64'(dram_data_out), 64'(e.dout));
                    end
                end
            end else begin
                chk("nop_fields_zero", 64'({cmd_we, cmd_bank, cmd_row, cmd_col, dram_data_out}), 64'(0));
            end
            if (busy) chk("ready_while_busy", 64'(req_ready), 64'(0));
            chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (!rst) begin
            while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                chk("rsp_missing_at_cycle", 64'(cyc), 64'(rsp_q[0].cyc));
                void'(rsp_q.pop_front());
            end
            if (rsp_valid != 8'h00) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rsp_valid", 64'(rsp_valid), 64'(e.vld));
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end
        end
    end

    // kind: 0 hit, 1 closed bank, 2 row conflict
    task automatic push_access(input int g, input int kind, input logic [12:0] addr,
                               input logic rw, input logic wd, input logic [7:0] oh,
                               input logic rdv);
        cmd_t c;
        rsp_t r;
        int   t;
        t      = g + 1;
        c.we   = 1'b0;
        c.dout = 1'b0;
        c.bank = addr[12:10];
        c.row  = addr[9:3];
        c.col  = addr[2:0];
        if (kind == 2) begin
            c.cyc = t; c.cmd = 2'b11; cmd_q.push_back(c);
            t += T_RP;
        end
        if (kind >= 1) begin
            c.cyc = t; c.cmd = 2'b01; cmd_q.push_back(c);
            t += T_RCD;
        end
        c.cyc  = t;
        c.cmd  = 2'b10;
        c.we   = rw;
        c.dout = rw ? wd : 1'b0;
        cmd_q.push_back(c);
        r.vld  = oh;
        if (rw) begin
            r.cyc  = t + 1;
            r.data = 1'b0;
        end else begin
            r.cyc    = t + T_CL + 1;
            r.data   = rdv;
            samp_cyc = t + T_CL;
            samp_val = rdv;
        end
        rsp_q.push_back(r);
    endtask

    task automatic wait_grant(input logic [7:0] exp_oh, output int g);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == 8'h00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 64'(req_ready), 64'(exp_oh));
        g = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((cmd_q.size() > 0 || rsp_q.size() > 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("drain_timeout", 64'(1), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic do_req(input int idx, input logic [12:0] addr, input logic rw,
                          input logic wd, input int kind, input logic rdv);
        int g;
        @(posedge clk); #1;
        req_valid[idx]         = 1'b1;
        req_addr[idx*13 +: 13] = addr;
        req_rw[idx]            = rw;
        req_wdata[idx]         = wd;
        wait_grant(8'(1 << idx), g);
        push_access(g, kind, addr, rw, wd, 8'(1 << idx), rdv);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_rw    = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd", 64'(cmd), 64'(0));
        chk("reset_addr_fields", 64'({cmd_we, cmd_bank, cmd_row, cmd_col, dram_data_out}), 64'(0));
        chk("reset_rsp", 64'({rsp_valid, rsp_data}), 64'(0));
        chk("reset_ready", 64'(req_ready), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        do_req(0, 13'h0000, 1'b0, 1'b0, 1, 1'b1);  // closed-bank read
        do_req(0, 13'h0001, 1'b0, 1'b0, 0, 1'b0);  // row hit, col 1
        do_req(0, 13'h0008, 1'b0, 1'b0, 2, 1'b1);  // conflict: bank0 row1
        do_req(3, 13'h1C05, 1'b1, 1'b1, 1, 1'b0);  // write, bank7 closed
        do_req(3, 13'h1C06, 1'b1, 1'b0, 0, 1'b0);  // write hit, wdata 0
        do_req(5, 13'h1C0E, 1'b0, 1'b0, 2, 1'b0);  // bank7 row1 conflict read

        // Reset during RD_WAIT on a hit to bank0 row1
        @(posedge clk); #1;
        req_valid[0]   = 1'b1;
        req_addr[12:0] = 13'h0008;
        req_rw[0]      = 1'b0;
        wait_grant(8'h01, g);
        begin
            cmd_t c;
            c.cyc = g + 1; c.cmd = 2'b10; c.we = 1'b0; c.dout = 1'b0;
            c.bank = 3'd0; c.row = 7'd1; c.col = 3'd0;
            cmd_q.push_back(c);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        samp_cyc = -1;
        @(negedge clk);
        chk("midreset_cmd", 64'(cmd), 64'(0));
        chk("midreset_busy", 64'(busy), 64'(0));
        chk("midreset_rsp", 64'(rsp_valid), 64'(0));
        repeat (10) @(negedge clk);
        do_req(0, 13'h0008, 1'b0, 1'b0, 1, 1'b1);  // table cleared: ACT again

        // Round robin: all requesters held high from reset, same bank/row
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 8'hFF;
        req_rw    = 8'h00;
        req_addr  = '0;
        for (int k = 0; k < 9; k++) begin
            wait_grant(8'(1 << (k % 8)), g);
            push_access(g, (k == 0) ? 1 : 0, 13'h0000, 1'b0, 1'b0, 8'(1 << (k % 8)), k[0]);
            @(posedge clk); #1;
            if (k == 8) req_valid = 8'h00;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
